// File: rtl/note_sequencer.sv
// One-shot tone player: latches a one-hot note select, plays a square wave
// for a note-dependent number of ticks, then an optional silent gap.
module note_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int QUARTER   = 25,
  parameter int HALF      = 50,
  parameter int WHOLE     = 100,
  parameter int GAP_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] note_sel,
  input  logic       start,
  input  logic       stop,
  output logic       speaker,
  output logic       busy,
  output logic       done,
  output logic       sel_err,
  output logic [2:0] note_idx
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int HP_MAX   = CLK_HZ / (2 * 261);
  localparam int DUR_MAX  = max2(max2(QUARTER, HALF), max2(WHOLE, GAP_TICKS));
  localparam int TONE_W   = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DUR_W    = $clog2(DUR_MAX + 1);

  typedef logic [TONE_W-1:0] tone_t;
  typedef logic [PRE_W-1:0]  pre_t;
  typedef logic [DUR_W-1:0]  dur_t;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // Half-period minus one, so the tone counter compares against its last value.
  localparam tone_t HP_M1 [8] = '{
    tone_t'(CLK_HZ / (2 * 261) - 1), tone_t'(CLK_HZ / (2 * 293) - 1),
    tone_t'(CLK_HZ / (2 * 329) - 1), tone_t'(CLK_HZ / (2 * 349) - 1),
    tone_t'(CLK_HZ / (2 * 392) - 1), tone_t'(CLK_HZ / (2 * 440) - 1),
    tone_t'(CLK_HZ / (2 * 493) - 1), tone_t'(CLK_HZ / (2 * 523) - 1)
  };

  localparam pre_t PRE_LAST = pre_t'(TICK_DIV - 1);
  localparam dur_t DUR_ONE  = dur_t'(1);
  localparam dur_t GAP_LEN  = dur_t'(GAP_TICKS);

  function automatic dur_t dur_of(input logic [2:0] idx);
    if (idx <= 3'd3)      return dur_t'(QUARTER);
    else if (idx <= 3'd6) return dur_t'(HALF);
    else                  return dur_t'(WHOLE);
  endfunction

  state_t     state;
  tone_t      tone_cnt;
  pre_t       pre_cnt;
  dur_t       dur_cnt;
  logic [2:0] sel_idx;
  logic       sel_valid;
  logic       tick;
  logic       tone_hit;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (note_sel[i]) sel_idx = 3'(i);
    end
  end

  assign sel_valid = (note_sel != '0) && ((note_sel & (note_sel - 8'd1)) == '0);
  assign tick      = (pre_cnt == PRE_LAST);
  assign tone_hit  = (tone_cnt == HP_M1[note_idx]);

  // NOTE: all state below uses <= so every register sees pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register, including note_idx, is reset; there is no memory here
    // whose reset could be skipped.
    if (rst) begin
      state    <= IDLE;
      speaker  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sel_err  <= 1'b0;
      note_idx <= '0;
      tone_cnt <= '0;
      pre_cnt  <= '0;
      dur_cnt  <= '0;
    end else begin
      done    <= 1'b0;
      sel_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (sel_valid) begin
              note_idx <= sel_idx;
              tone_cnt <= '0;
              pre_cnt  <= '0;
              dur_cnt  <= dur_of(sel_idx);
              speaker  <= 1'b0;
              busy     <= 1'b1;
              state    <= PLAY;
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (stop) begin
            state    <= IDLE;
            speaker  <= 1'b0;
            busy     <= 1'b0;
            tone_cnt <= '0;
            pre_cnt  <= '0;
            dur_cnt  <= '0;
          end else begin
            if (tone_hit) begin
              speaker  <= ~speaker;
              tone_cnt <= '0;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
            if (tick) begin
              pre_cnt <= '0;
              if (dur_cnt == DUR_ONE) begin
                // Final tick: silence and leave PLAY; a zero-length gap finishes here.
                speaker  <= 1'b0;
                tone_cnt <= '0;
                if (GAP_TICKS == 0) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  dur_cnt <= '0;
                end else begin
                  state   <= GAP;
                  dur_cnt <= GAP_LEN;
                end
              end else begin
                dur_cnt <= dur_cnt - 1'b1;
              end
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          speaker <= 1'b0;
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pre_cnt <= '0;
            dur_cnt <= '0;
          end else if (tick) begin
            pre_cnt <= '0;
            if (dur_cnt == DUR_ONE) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              dur_cnt <= '0;
            end else begin
              dur_cnt <= dur_cnt - 1'b1;
            end
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench: one instance at CLK_HZ=104400 with a 5-tick gap, and a
// second at CLK_HZ=10440 with no gap for end-of-note timing.
module tb_note_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stop;
  logic [7:0] note_sel;
  logic       speaker, busy, done, sel_err;
  logic [2:0] note_idx;

  logic       rst0, start0, stop0;
  logic [7:0] note_sel0;
  logic       speaker0, busy0, done0, sel_err0;
  logic [2:0] note_idx0;

  note_sequencer #(.CLK_HZ(104400), .TICK_HZ(100), .GAP_TICKS(5)) dut (
    .clk(clk), .rst(rst), .note_sel(note_sel), .start(start), .stop(stop),
    .speaker(speaker), .busy(busy), .done(done), .sel_err(sel_err),
    .note_idx(note_idx)
  );

  note_sequencer #(.CLK_HZ(10440), .TICK_HZ(100), .GAP_TICKS(0)) dut0 (
    .clk(clk), .rst(rst0), .note_sel(note_sel0), .start(start0), .stop(stop0),
    .speaker(speaker0), .busy(busy0), .done(done0), .sel_err(sel_err0),
    .note_idx(note_idx0)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return speaker;
      1:       return done;
      2:       return speaker0;
      default: return done0;
    endcase
  endfunction

  // Edges waited until the selected signal reaches lvl, capped at bound.
  task automatic wait_for(input int which, input logic lvl, input int bound, output int n);
    n = 0;
    while (sig(which) !== lvl && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("wait_sig%0d", which), {31'd0, sig(which)}, {31'd0, lvl});
  endtask

  int n, t;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; note_sel = '0;
    rst0 = 1'b1; start0 = 1'b0; stop0 = 1'b0; note_sel0 = '0;
    #23;
    check("rst_speaker", speaker, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sel_err", sel_err, 1'b0);
    check("rst_note_idx", note_idx, 3'd0);
    check("rst_busy0", busy0, 1'b0);
    rst = 1'b0; rst0 = 1'b0;
    step(2);

    // Invalid selects
    note_sel = 8'h03; start = 1'b1; step(1); start = 1'b0;
    check("multi_sel_err", sel_err, 1'b1);
    check("multi_busy", busy, 1'b0);
    step(1);
    check("multi_sel_err_pulse", sel_err, 1'b0);
    check("multi_speaker", speaker, 1'b0);
    note_sel = 8'h00; start = 1'b1; step(1); start = 1'b0;
    check("zero_sel_err", sel_err, 1'b1);
    check("zero_busy", busy, 1'b0);
    step(1);
    check("zero_sel_err_pulse", sel_err, 1'b0);

    // stop in IDLE blocks a valid start
    note_sel = 8'h01; start = 1'b1; stop = 1'b1; step(1);
    start = 1'b0; stop = 1'b0;
    check("stop_blocks_busy", busy, 1'b0);
    check("stop_blocks_sel_err", sel_err, 1'b0);

    // C4 full note
    start = 1'b1; step(1); start = 1'b0; t = cyc;
    check("c4_busy", busy, 1'b1);
    check("c4_idx", note_idx, 3'd0);
    check("c4_speaker0", speaker, 1'b0);
    wait_for(0, 1'b1, 1000, n);
    check("c4_first_toggle", n, 200);
    wait_for(0, 1'b0, 1000, n);
    check("c4_second_toggle", n, 200);
    wait_for(1, 1'b1, 40000, n);
    check("c4_busy_len", cyc - t, 31320);
    check("c4_busy_at_done", busy, 1'b0);
    check("c4_speaker_at_done", speaker, 1'b0);
    step(1);
    check("c4_done_pulse", done, 1'b0);

    // A4: half-period, ignored start/select in PLAY, stop in PLAY
    note_sel = 8'h20; start = 1'b1; step(1); start = 1'b0;
    check("a4_idx", note_idx, 3'd5);
    wait_for(0, 1'b1, 1000, n);
    check("a4_first_toggle", n, 118);
    note_sel = 8'h04; start = 1'b1; step(1); start = 1'b0;
    check("a4_idx_held", note_idx, 3'd5);
    check("a4_busy_held", busy, 1'b1);
    check("a4_no_sel_err", sel_err, 1'b0);
    check("a4_speaker_high", speaker, 1'b1);
    stop = 1'b1; step(1); stop = 1'b0;
    check("a4_stop_busy", busy, 1'b0);
    check("a4_stop_speaker", speaker, 1'b0);
    check("a4_stop_done", done, 1'b0);

    // C5 stopped at cycle 1000, G4 accepted on the following edge
    note_sel = 8'h80; start = 1'b1; step(1); start = 1'b0;
    check("c5_idx", note_idx, 3'd7);
    check("c5_busy", busy, 1'b1);
    step(999);
    stop = 1'b1; step(1); stop = 1'b0;
    note_sel = 8'h10; start = 1'b1;
    check("c5_stop_busy", busy, 1'b0);
    check("c5_stop_done", done, 1'b0);
    check("c5_stop_speaker", speaker, 1'b0);
    step(1); start = 1'b0;
    check("g4_busy", busy, 1'b1);
    check("g4_idx", note_idx, 3'd4);
    wait_for(0, 1'b1, 1000, n);
    check("g4_first_toggle", n, 133);

    // Async reset between edges, held start replays G4 after release
    step(3);
    #3; rst = 1'b1; start = 1'b1;
    #2;
    check("arst_speaker", speaker, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_idx", note_idx, 3'd0);
    check("arst_done", done, 1'b0);
    #2; rst = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    check("replay_busy", busy, 1'b1);
    check("replay_idx", note_idx, 3'd4);
    wait_for(0, 1'b1, 1000, n);
    check("replay_first_toggle", n, 133);
    stop = 1'b1; step(1); stop = 1'b0;
    check("replay_stop_busy", busy, 1'b0);
    check("done_pulse_count", done_cnt, 1);

    // No-gap build: WHOLE note ends with done on the busy-falling edge
    note_sel0 = 8'h80; start0 = 1'b1; step(1); start0 = 1'b0; t = cyc;
    check("g0_c5_busy", busy0, 1'b1);
    wait_for(3, 1'b1, 12000, n);
    check("g0_c5_len", cyc - t, 10400);
    check("g0_c5_busy_fall", busy0, 1'b0);
    step(1);
    check("g0_c5_done_pulse", done0, 1'b0);

    // No-gap A4 with start held and select changed mid-note, then retrigger
    note_sel0 = 8'h20; start0 = 1'b1; step(1); t = cyc;
    check("g0_a4_idx", note_idx0, 3'd5);
    note_sel0 = 8'h01;
    wait_for(2, 1'b1, 100, n);
    check("g0_a4_first_toggle", n, 11);
    check("g0_a4_idx_held", note_idx0, 3'd5);
    wait_for(3, 1'b1, 6000, n);
    check("g0_a4_len", cyc - t, 5200);
    check("g0_a4_busy_fall", busy0, 1'b0);
    step(1);
    check("g0_retrigger_busy", busy0, 1'b1);
    check("g0_retrigger_idx", note_idx0, 3'd0);
    check("g0_retrigger_done", done0, 1'b0);
    start0 = 1'b0; stop0 = 1'b1; step(1); stop0 = 1'b0;
    check("g0_stop_busy", busy0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000: system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100: duration tick rate; TICK_DIV = CLK_HZ/TICK_HZ, integer floor.
REQ-003 SHALL have parameters QUARTER, HALF, WHOLE, defaults 25, 50, 100: note lengths in ticks.
REQ-004 SHALL have parameter GAP_TICKS, default 5: silent ticks after each note; 0 allowed.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port note_sel, input, 8 bits: one-hot note select; bit0=C4, bit1=D4, bit2=E4, bit3=F4, bit4=G4, bit5=A4, bit6=B4, bit7=C5.
REQ-008 SHALL have port start, input, 1 bit: play request, level-sampled.
REQ-009 SHALL have port stop, input, 1 bit: abort request.
REQ-010 SHALL have port speaker, output, 1 bit: square-wave tone.
REQ-011 SHALL have port busy, output, 1 bit: high in PLAY or GAP.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on normal note completion.
REQ-013 SHALL have port sel_err, output, 1 bit: one-cycle pulse on an invalid start.
REQ-014 SHALL have port note_idx, output, 3 bits: index of the latched note.

Function
REQ-015 SHALL use fixed note frequencies (Hz): 261, 293, 329, 349, 392, 440, 493, 523.
REQ-016 SHALL compute half-period HP[i] = floor(CLK_HZ/(2*f[i])) at elaboration; no runtime division.
REQ-017 SHALL assign duration by note index: 0-3 -> QUARTER, 4-6 -> HALF, 7 -> WHOLE.
REQ-018 SHALL implement states IDLE, PLAY, GAP.
REQ-019 In IDLE with start=1 and note_sel exactly one-hot, SHALL on that edge latch the note into note_idx, clear the tone counter, clear the tick prescaler, load the duration counter, set speaker=0, and enter PLAY.
REQ-020 In IDLE with start=1 and note_sel zero or multi-hot, SHALL pulse sel_err for 1 cycle and stay in IDLE.
REQ-021 While start is held in IDLE, SHALL evaluate start every cycle, so a held start retriggers immediately after return to IDLE.
REQ-022 In PLAY, SHALL increment the tone counter each cycle and, at HP[note_idx]-1, toggle speaker and clear the counter; first toggle is exactly HP cycles after PLAY entry.
REQ-023 In PLAY, SHALL count prescaler 0..TICK_DIV-1 and decrement the duration counter on wrap; at the final wrap (counter 1->0) SHALL enter GAP, so PLAY lasts exactly duration*TICK_DIV cycles.
REQ-024 In GAP, SHALL hold speaker=0, clear the prescaler on entry, and count GAP_TICKS ticks; then enter IDLE and pulse done in the same cycle.
REQ-025 If GAP_TICKS=0, SHALL go PLAY->IDLE directly with the done pulse on the transition edge.
REQ-026 SHALL ignore start and note_sel changes in PLAY and GAP; note_idx is stable until the next accepted start.
REQ-027 With stop=1 in PLAY or GAP, SHALL go to IDLE next edge with speaker=0 and no done pulse; stop wins over a same-cycle completion.
REQ-028 stop=1 in IDLE SHALL have no effect and SHALL also block acceptance of start that cycle.
REQ-029 busy SHALL be registered, high exactly in PLAY and GAP.
REQ-030 Counters SHALL be sized by $clog2 of their maximum value; no counter SHALL wrap outside the rules above.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, speaker=0, busy=0, done=0, sel_err=0, note_idx=0, and all counters 0, regardless of clock.
REQ-032 rst asserted mid-PLAY or mid-GAP SHALL abort the note with no done pulse; operation resumes on the first edge after deassertion.

Verification (CLK_HZ=104400, TICK_HZ=100 -> TICK_DIV=1044, GAP_TICKS=5)
REQ-033 note_sel=0x01, start pulse -> speaker toggles every 200 cycles, busy high 25*1044+5*1044=31320 cycles, then done pulse once.
REQ-034 note_sel=0x20, start -> HP=118 (floor); PLAY 50*1044=52200 cycles; note_idx=5.
REQ-035 note_sel=0x03 or 0x00 with start -> sel_err one pulse, busy stays 0, speaker stays 0.
REQ-036 stop at cycle 1000 of a C5 note -> IDLE next edge, speaker=0, no done; a new start accepted the following cycle.
REQ-037 Async rst mid-PLAY between clock edges -> outputs zero before the next edge; a held start after release replays the selected note.
REQ-038 GAP_TICKS=0 build, note 0x80 -> done exactly 100*1044 cycles after the accepting edge; busy falls on the same edge.
